// File: rtl/slice_sched_if.sv
// Handshake/bus bundle joining slice_sched to the line memory, the slice datapath and the result buffer.
interface slice_sched_if #(
   parameter int unsigned WIDTH  = 25,
   parameter int unsigned ADDR_W = 6
);
   logic              start;
   logic              busy;
   logic              finish;
   logic [ADDR_W-1:0] slice_idx;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [WIDTH-1:0]  mem_rdata;
   logic              dp_go;
   logic [WIDTH-1:0]  dp_line;
   logic              dp_done;
   logic [WIDTH-1:0]  dp_result;
   logic              res_we;
   logic [ADDR_W-1:0] res_addr;
   logic [WIDTH-1:0]  res_data;
   logic              timeout_err;

   modport slave (
      input  start, mem_rdata, dp_done, dp_result,
      output busy, finish, slice_idx, mem_rd, mem_addr, dp_go, dp_line,
             res_we, res_addr, res_data, timeout_err
   );

   modport master (
      output start, mem_rdata, dp_done, dp_result,
      input  busy, finish, slice_idx, mem_rd, mem_addr, dp_go, dp_line,
             res_we, res_addr, res_data, timeout_err
   );
endinterface

// File: rtl/slice_sched.sv
// Streams 2**ADDR_W line slices through the permutation datapath and stores each result.
// Define WATCHDOG_EN to bound the WAIT state by TIMEOUT cycles and build the sticky timeout_err flag.
module slice_sched #(
   parameter int unsigned WIDTH   = 25,
   parameter int unsigned ADDR_W  = 6
`ifdef WATCHDOG_EN
  ,parameter int unsigned TIMEOUT = 255
`endif
) (
   input  logic         clk,
   input  logic         rst,
   slice_sched_if.slave io_ss
);
   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_LATCH, S_GO, S_WAIT, S_STORE, S_FIN
   } state_t;

   state_t            r_state, w_nxt_state;
   logic [ADDR_W-1:0] r_idx,   w_nxt_idx;
   logic [WIDTH-1:0]  r_line,  w_nxt_line;
   logic [WIDTH-1:0]  r_res,   w_nxt_res;
   logic              r_busy,   w_nxt_busy;
   logic              r_finish, w_nxt_finish;
   logic              r_mem_rd, w_nxt_mem_rd;
   logic              r_dp_go,  w_nxt_dp_go;
   logic              r_res_we, w_nxt_res_we;
   logic              w_last;

`ifdef WATCHDOG_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]  r_cnt,  w_nxt_cnt;
   logic              r_terr, w_nxt_terr;
`endif

   assign w_last = (r_idx == {ADDR_W{1'b1}});

   // Next-state, datapath registers and registered-output decode
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_idx   = r_idx;
      w_nxt_line  = r_line;
      w_nxt_res   = r_res;
`ifdef WATCHDOG_EN
      w_nxt_cnt   = r_cnt;
      w_nxt_terr  = r_terr;
`endif
      case (r_state)
         S_IDLE: begin
            w_nxt_idx = '0;
            if (io_ss.start) begin
               w_nxt_state = S_READ;
`ifdef WATCHDOG_EN
               w_nxt_terr  = 1'b0;
`endif
            end
         end
         S_READ:  w_nxt_state = S_LATCH;
         S_LATCH: begin
            w_nxt_line  = io_ss.mem_rdata;
            w_nxt_state = S_GO;
         end
         S_GO: begin
            w_nxt_state = S_WAIT;
`ifdef WATCHDOG_EN
            w_nxt_cnt   = '0;
`endif
         end
         S_WAIT: begin
            if (io_ss.dp_done) begin
               w_nxt_res   = io_ss.dp_result;
               w_nxt_state = S_STORE;
            end
`ifdef WATCHDOG_EN
            // Abandon a stuck slice: store all-ones and flag it, then carry on
            else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_nxt_res   = '1;
               w_nxt_terr  = 1'b1;
               w_nxt_state = S_STORE;
            end else begin
               w_nxt_cnt   = r_cnt + 1'b1;
            end
`endif
         end
         S_STORE: begin
            if (w_last) begin
               w_nxt_state = S_FIN;
            end else begin
               w_nxt_idx   = r_idx + 1'b1;
               w_nxt_state = S_READ;
            end
         end
         S_FIN: begin
            w_nxt_idx   = '0;
            w_nxt_state = S_IDLE;
         end
         default: w_nxt_state = S_IDLE;
      endcase

      w_nxt_busy   = (w_nxt_state != S_IDLE);
      w_nxt_finish = (w_nxt_state == S_FIN);
      w_nxt_mem_rd = (w_nxt_state == S_READ);
      w_nxt_dp_go  = (w_nxt_state == S_GO);
      w_nxt_res_we = (w_nxt_state == S_STORE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_line   <= '0;
         r_res    <= '0;
         r_busy   <= 1'b0;
         r_finish <= 1'b0;
         r_mem_rd <= 1'b0;
         r_dp_go  <= 1'b0;
         r_res_we <= 1'b0;
      end else begin
         r_state  <= w_nxt_state;
         r_idx    <= w_nxt_idx;
         r_line   <= w_nxt_line;
         r_res    <= w_nxt_res;
         r_busy   <= w_nxt_busy;
         r_finish <= w_nxt_finish;
         r_mem_rd <= w_nxt_mem_rd;
         r_dp_go  <= w_nxt_dp_go;
         r_res_we <= w_nxt_res_we;
      end
   end

`ifdef WATCHDOG_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt  <= '0;
         r_terr <= 1'b0;
      end else begin
         r_cnt  <= w_nxt_cnt;
         r_terr <= w_nxt_terr;
      end
   end

   assign io_ss.timeout_err = r_terr;
`else
   assign io_ss.timeout_err = 1'b0;
`endif

   assign io_ss.busy      = r_busy;
   assign io_ss.finish    = r_finish;
   assign io_ss.slice_idx = r_idx;
   assign io_ss.mem_rd    = r_mem_rd;
   assign io_ss.mem_addr  = r_idx;
   assign io_ss.dp_go     = r_dp_go;
   assign io_ss.dp_line   = r_line;
   assign io_ss.res_we    = r_res_we;
   assign io_ss.res_addr  = r_idx;
   assign io_ss.res_data  = r_res;
endmodule

// File: tb/tb_slice_sched.sv
// Self-checking bench for slice_sched: randomized memory contents and datapath latency,
// checked against a per-slice schedule/result model (write order, data, spacing 4+n, finish time).
module tb_slice_sched;
   localparam int unsigned W  = 25;
   localparam int unsigned AW = 6;
   localparam int          N  = 64;
`ifdef WATCHDOG_EN
   localparam int          TMO = 8;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   logic [W-1:0] mem [N];
   int           lat_tab [N];
   int           hold_idx = -1;
   bit           bogus_en = 1'b0;

   int           wr_addr_q [$];
   logic [W-1:0] wr_data_q [$];
   int           wr_cyc_q  [$];

   logic         rd_prev = 1'b0;
   bit           dp_pend = 1'b0;
   int           dp_cnt  = 0;

   slice_sched_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

   slice_sched #(
      .WIDTH  (W),
      .ADDR_W (AW)
`ifdef WATCHDOG_EN
     ,.TIMEOUT(TMO)
`endif
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .io_ss (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] dp_model(input logic [W-1:0] x);
      return {x[W-8:0], x[W-1:W-7]} ^ 25'h0A55A5A;
   endfunction

   // Number of WAIT cycles slice i is expected to spend
   function automatic int n_of(input int i);
`ifdef WATCHDOG_EN
      if (i == hold_idx) return TMO;
`endif
      return lat_tab[i] + 1;
   endfunction

   function automatic logic [W-1:0] exp_of(input int i);
`ifdef WATCHDOG_EN
      if (i == hold_idx) return '1;
`endif
      return dp_model(mem[i]);
   endfunction

   // Line memory: data appears the cycle after the read strobe and holds through that cycle
   always @(negedge clk) begin
      if (bus.mem_rd) bus.mem_rdata = mem[bus.mem_addr];
      else if (!rd_prev) bus.mem_rdata = W'($urandom);
      rd_prev = bus.mem_rd;
   end

   // Datapath: dp_done lat_tab[idx] cycles after the first WAIT cycle; junk result otherwise
   always @(negedge clk or negedge rst) begin
      if (!rst) begin
         dp_pend = 1'b0;
         bus.dp_done = 1'b0;
         bus.dp_result = '0;
      end else begin
         bus.dp_done = 1'b0;
         bus.dp_result = W'($urandom);
         if (dp_pend) begin
            if (dp_cnt == 0) begin
               bus.dp_done = 1'b1;
               bus.dp_result = dp_model(bus.dp_line);
               dp_pend = 1'b0;
            end else begin
               dp_cnt--;
            end
         end
         if (bus.dp_go) begin
            if (bogus_en) begin
               bus.dp_done = 1'b1;
               bus.dp_result = 25'h0BADBAD;
            end
            dp_pend = (int'(bus.slice_idx) != hold_idx);
            dp_cnt  = lat_tab[int'(bus.slice_idx)];
         end
      end
   end

   always @(negedge clk) begin
      if (rst && bus.res_we) begin
         wr_addr_q.push_back(int'(bus.res_addr));
         wr_data_q.push_back(bus.res_data);
         wr_cyc_q.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_busy"},   32'(bus.busy), 0);
      chk({pfx, "_finish"}, 32'(bus.finish), 0);
      chk({pfx, "_mem_rd"}, 32'(bus.mem_rd), 0);
      chk({pfx, "_dp_go"},  32'(bus.dp_go), 0);
      chk({pfx, "_res_we"}, 32'(bus.res_we), 0);
      chk({pfx, "_terr"},   32'(bus.timeout_err), 0);
      chk({pfx, "_idx"},    32'(bus.slice_idx), 0);
      chk({pfx, "_maddr"},  32'(bus.mem_addr), 0);
      chk({pfx, "_raddr"},  32'(bus.res_addr), 0);
      chk({pfx, "_line"},   32'(bus.dp_line), 0);
      chk({pfx, "_rdata"},  32'(bus.res_data), 0);
   endtask

   task automatic fill(input bit ramp, input bit rnd_lat);
      for (int i = 0; i < N; i++) begin
         mem[i]     = ramp ? W'(i) : W'($urandom);
         lat_tab[i] = rnd_lat ? int'($urandom_range(0, 9)) : 0;
      end
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
   endtask

   task automatic start_run(input bit hold, output int a);
      @(negedge clk);
      clear_log();
      bus.start = 1'b1;
      a = cyc;
      @(negedge clk);
      chk("first_rd",   32'(bus.mem_rd), 1);
      chk("busy_rise",  32'(bus.busy), 1);
      chk("first_addr", 32'(bus.mem_addr), 0);
      chk("terr_clear", 32'(bus.timeout_err), 0);
      if (!hold) bus.start = 1'b0;
   endtask

   task automatic wait_fin(output int f);
      f = -1;
      for (int k = 0; k < 3000 && f < 0; k++) begin
         @(negedge clk);
         if (bus.finish) f = cyc;
      end
      chk("finish_seen", 32'(f >= 0), 1);
   endtask

   task automatic check_run(input int a, input int f);
      int t;
      t = a;
      chk("wr_count", 32'(wr_addr_q.size()), 32'(N));
      for (int i = 0; i < N; i++) begin
         t += 4 + n_of(i);
         if (i < wr_addr_q.size()) begin
            chk("wr_addr", 32'(wr_addr_q[i]), 32'(i));
            chk("wr_data", 32'(wr_data_q[i]), 32'(exp_of(i)));
            chk("wr_time", 32'(wr_cyc_q[i] - a), 32'(t - a));
         end
      end
      chk("fin_time", 32'(f - a), 32'(t + 1 - a));
      @(negedge clk);
      chk("busy_fall", 32'(bus.busy), 0);
   endtask

   initial begin
      int a;
      int f;
      bit found;

      bus.start = 1'b0;
      fill(1'b1, 1'b0);
      repeat (3) @(negedge clk);
      chk_zero("rst");
      rst = 1'b1;
      @(negedge clk);
      chk_zero("idle");

      // Ramp memory, one-cycle datapath
      start_run(1'b0, a);
      wait_fin(f);
      check_run(a, f);
      chk("fin_321", 32'(f - a), 321);

      // Random data and latency
      fill(1'b0, 1'b1);
      start_run(1'b0, a);
      wait_fin(f);
      check_run(a, f);

      // Bogus done in GO, start held through FIN into IDLE
      fill(1'b0, 1'b1);
      lat_tab[10] = 5;
      bogus_en = 1'b1;
      start_run(1'b1, a);
      wait_fin(f);
      check_run(a, f);
      clear_log();
      @(negedge clk);
      chk("restart_rd",   32'(bus.mem_rd), 1);
      chk("restart_busy", 32'(bus.busy), 1);
      bus.start = 1'b0;

      // Reset while slice 10 is waiting on the datapath
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         @(negedge clk);
         if (bus.dp_go && bus.slice_idx == 6'd10) found = 1'b1;
      end
      chk("slice10_go", 32'(found), 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_zero("midrst");
      chk("midrst_wr_count", 32'(wr_addr_q.size()), 10);
      if (wr_addr_q.size() > 0) chk("midrst_last_addr", 32'(wr_addr_q[wr_addr_q.size()-1]), 9);
      repeat (3) begin
         @(negedge clk);
         chk("midrst_no_we", 32'(bus.res_we), 0);
      end
      bogus_en = 1'b0;
      rst = 1'b1;

      repeat (5) begin
         @(negedge clk);
         chk("quiet_busy", 32'(bus.busy), 0);
         chk("quiet_rd",   32'(bus.mem_rd), 0);
      end

      // Restart from slice 0
      fill(1'b0, 1'b1);
      start_run(1'b0, a);
      wait_fin(f);
      check_run(a, f);

`ifdef WATCHDOG_EN
      // Slice 5 never completes
      fill(1'b0, 1'b1);
      hold_idx = 5;
      start_run(1'b0, a);
      wait_fin(f);
      check_run(a, f);
      chk("terr_sticky", 32'(bus.timeout_err), 1);
      hold_idx = -1;
      fill(1'b0, 1'b1);
      start_run(1'b0, a);
      wait_fin(f);
      check_run(a, f);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
